// File: rtl/f_result_serializer.sv
// Captures {a,b,c,d,F1,F2,F3} words into a FIFO and shifts them out on a serial line.
// Define F_RESULT_SERIALIZER_PARITY_EN to add an even-parity bit before the stop bit.
module f_result_serializer #(
  parameter int DEPTH   = 4,
  parameter int BIT_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       a,
  input  logic                       b,
  input  logic                       c,
  input  logic                       d,
  input  logic                       F1,
  input  logic                       F2,
  input  logic                       F3,
  input  logic                       ovf_clr,
  output logic                       ser_out,
  output logic                       ser_busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] RELOAD = 8'(BIT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef F_RESULT_SERIALIZER_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      sh_q, sh_d;
  logic            ser_q, ser_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic [6:0]      mem [DEPTH];
  logic [6:0]      word;
  logic [6:0]      head;
  logic            push, pop, drop;

  assign word     = {a, b, c, d, F1, F2, F3};
  assign head     = mem[rptr_q];
  assign in_ready = (count_q < FULL);
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = head;
          state_d = START;
          timer_d = RELOAD;
        end
      end
      START: begin
        if (timer_q == 8'd0) begin
          state_d = DATA;
          bit_d   = 3'd6;
          timer_d = RELOAD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      DATA: begin
        if (timer_q == 8'd0) begin
          timer_d = RELOAD;
          if (bit_q == 3'd0) begin
`ifdef F_RESULT_SERIALIZER_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
`ifdef F_RESULT_SERIALIZER_PARITY_EN
      PAR: begin
        if (timer_q == 8'd0) begin
          state_d = STOP;
          timer_d = RELOAD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
`endif
      STOP: begin
        if (timer_q == 8'd0) begin
          // Chain straight into the next START so frames stay contiguous
          if (count_q != '0) begin
            pop     = 1'b1;
            sh_d    = head;
            state_d = START;
            timer_d = RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ser_d  = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = sh_d[bit_d];
`ifdef F_RESULT_SERIALIZER_PARITY_EN
      PAR:     ser_d = ^sh_d;
`endif
      default: ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= 8'd0;
      bit_q   <= 3'd0;
      sh_q    <= 7'd0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= word;
  end

  assign ser_out    = ser_q;
  assign ser_busy   = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_f_result_serializer.sv
// Bench for f_result_serializer: two instances (BIT_DIV 4 and 1) against a frame-level model.
module tb_f_result_serializer;

  localparam int DEPTH = 4;
`ifdef F_RESULT_SERIALIZER_PARITY_EN
  localparam int NB = 10;
  localparam bit PAR_ON = 1'b1;
`else
  localparam int NB = 9;
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk, rst_n;
  logic       vin [2];
  logic [6:0] win [2];
  logic       clr [2];
  logic       rdy [2];
  logic       ser [2];
  logic       busy [2];
  logic       ovf [2];
  logic [2:0] cnt [2];

  int bd [2];
  int checks, errors;

  // Reference model: plain list of queued words plus a frame-elapsed counter
  logic [6:0] mbuf [2][DEPTH];
  int         mcnt [2];
  bit         mbusy [2];
  int         mel [2];
  logic [6:0] mcur [2];
  bit         movf [2];
  int         runlen [2];
  int         last_run [2];

  f_result_serializer #(.DEPTH(DEPTH), .BIT_DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]),
    .a(win[0][6]), .b(win[0][5]), .c(win[0][4]), .d(win[0][3]),
    .F1(win[0][2]), .F2(win[0][1]), .F3(win[0][0]), .ovf_clr(clr[0]),
    .ser_out(ser[0]), .ser_busy(busy[0]), .overflow(ovf[0]),
    .fifo_count(cnt[0])
  );

  f_result_serializer #(.DEPTH(DEPTH), .BIT_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]),
    .a(win[1][6]), .b(win[1][5]), .c(win[1][4]), .d(win[1][3]),
    .F1(win[1][2]), .F2(win[1][1]), .F3(win[1][0]), .ovf_clr(clr[1]),
    .ser_out(ser[1]), .ser_busy(busy[1]), .overflow(ovf[1]),
    .fifo_count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic fbit(logic [6:0] w, int i);
    if (i == 0) return 1'b0;
    if (i <= 7) return w[7-i];
    if (PAR_ON && i == 8) return ^w;
    return 1'b1;
  endfunction

  function automatic void mreset(int k);
    mcnt[k] = 0;
    mbusy[k] = 1'b0;
    mel[k] = 0;
    movf[k] = 1'b0;
  endfunction

  function automatic void medge(int k);
    bit ready, push, drop, popnow;
    ready = (mcnt[k] < DEPTH);
    push = vin[k] && ready;
    drop = vin[k] && !ready;
    popnow = 1'b0;
    if (mbusy[k]) begin
      mel[k]++;
      if (mel[k] == NB * bd[k]) begin
        if (mcnt[k] > 0) popnow = 1'b1;
        else mbusy[k] = 1'b0;
      end
    end else if (mcnt[k] > 0) begin
      popnow = 1'b1;
    end
    if (popnow) begin
      mcur[k] = mbuf[k][0];
      for (int j = 0; j < DEPTH - 1; j++) mbuf[k][j] = mbuf[k][j+1];
      mcnt[k]--;
      mbusy[k] = 1'b1;
      mel[k] = 0;
    end
    if (push) begin
      mbuf[k][mcnt[k]] = win[k];
      mcnt[k]++;
    end
    if (drop) movf[k] = 1'b1;
    else if (clr[k]) movf[k] = 1'b0;
  endfunction

  task automatic mcompare(int k);
    logic exp_ser;
    exp_ser = mbusy[k] ? fbit(mcur[k], mel[k] / bd[k]) : 1'b1;
    chk("m_ser", k, int'(ser[k]), int'(exp_ser));
    chk("m_busy", k, int'(busy[k]), int'(mbusy[k]));
    chk("m_count", k, int'(cnt[k]), mcnt[k]);
    chk("m_ovf", k, int'(ovf[k]), int'(movf[k]));
    chk("m_ready", k, int'(rdy[k]), int'(mcnt[k] < DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) mreset(k);
      else medge(k);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      mcompare(k);
      if (busy[k]) runlen[k]++;
      else if (runlen[k] > 0) begin
        last_run[k] = runlen[k];
        runlen[k] = 0;
      end
    end
  endtask

  task automatic wait_idle(int k);
    int n;
    n = 0;
    while ((busy[k] || cnt[k] != 0) && n < 2000) begin
      step();
      n++;
    end
    chk("idle_wait", k, int'(n < 2000), 1);
  endtask

  task automatic run_frame(int k, logic [6:0] w, logic [9:0] fr);
    wait_idle(k);
    vin[k] = 1'b1;
    win[k] = w;
    step();
    vin[k] = 1'b0;
    chk("push_count", k, int'(cnt[k]), 1);
    for (int c = 0; c < NB * bd[k]; c++) begin
      step();
      chk("line", k, int'(ser[k]), int'(fr[NB-1-c/bd[k]]));
      chk("busy_on", k, int'(busy[k]), 1);
      if (c == 0) chk("pop_count", k, int'(cnt[k]), 0);
    end
    step();
    chk("busy_off", k, int'(busy[k]), 0);
    chk("line_idle", k, int'(ser[k]), 1);
  endtask

  typedef struct {
    int         k;
    logic [6:0] w;
    logic [9:0] fr;
  } vec_t;

  vec_t vecs [4];
  int   seen;

  initial begin
    checks = 0;
    errors = 0;
    bd[0] = 4;
    bd[1] = 1;
`ifdef F_RESULT_SERIALIZER_PARITY_EN
    vecs[0] = '{0, 7'h5C, 10'b0101110001};
    vecs[1] = '{1, 7'h7F, 10'b0111111111};
    vecs[2] = '{0, 7'h00, 10'b0000000001};
    vecs[3] = '{1, 7'h01, 10'b0000000111};
`else
    vecs[0] = '{0, 7'h5C, 10'b0010111001};
    vecs[1] = '{1, 7'h7F, 10'b0011111111};
    vecs[2] = '{0, 7'h00, 10'b0000000001};
    vecs[3] = '{1, 7'h01, 10'b0000000011};
`endif
    for (int k = 0; k < 2; k++) begin
      vin[k] = 1'b0;
      win[k] = 7'd0;
      clr[k] = 1'b0;
      runlen[k] = 0;
      last_run[k] = 0;
      mreset(k);
    end
    rst_n = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ser", k, int'(ser[k]), 1);
      chk("rst_busy", k, int'(busy[k]), 0);
      chk("rst_ready", k, int'(rdy[k]), 1);
      chk("rst_count", k, int'(cnt[k]), 0);
      chk("rst_ovf", k, int'(ovf[k]), 0);
    end
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_frame(vecs[i].k, vecs[i].w, vecs[i].fr);

    // Fill and overflow behind a running frame
    wait_idle(0);
    vin[0] = 1'b1;
    win[0] = 7'h2A;
    step();
    vin[0] = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      vin[0] = 1'b1;
      win[0] = 7'(i * 19 + 3);
      step();
      if (i == 3) begin
        chk("full_count", 0, int'(cnt[0]), 4);
        chk("full_ready", 0, int'(rdy[0]), 0);
        chk("full_noovf", 0, int'(ovf[0]), 0);
      end
    end
    vin[0] = 1'b0;
    chk("drop_ovf", 0, int'(ovf[0]), 1);
    chk("drop_count", 0, int'(cnt[0]), 4);
    step();
    step();
    chk("ovf_sticky", 0, int'(ovf[0]), 1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("ovf_clr", 0, int'(ovf[0]), 0);
    wait_idle(0);
    step();
    chk("five_frames", 0, last_run[0], 5 * NB * 4);

    // Drop and clear in the same cycle leaves overflow set
    wait_idle(0);
    vin[0] = 1'b1;
    for (int i = 0; i < 6; i++) step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    vin[0] = 1'b0;
    chk("clr_vs_drop", 0, int'(ovf[0]), 1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    wait_idle(0);

    // Back-to-back frames on both rates
    for (int k = 0; k < 2; k++) begin
      wait_idle(k);
      step();
      for (int i = 0; i < 3; i++) begin
        vin[k] = 1'b1;
        win[k] = 7'(i * 37 + 11);
        step();
      end
      vin[k] = 1'b0;
      chk("b2b_count", k, int'(cnt[k]), 2);
      wait_idle(k);
      step();
      chk("b2b_run", k, last_run[k], 3 * NB * bd[k]);
    end

    // Reset during DATA bit 3 with two words queued
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      vin[0] = 1'b1;
      win[0] = 7'(i + 100);
      step();
    end
    vin[0] = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("pre_rst_busy", 0, int'(busy[0]), 1);
    chk("pre_rst_count", 0, int'(cnt[0]), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ser", 0, int'(ser[0]), 1);
    chk("mid_rst_busy", 0, int'(busy[0]), 0);
    chk("mid_rst_count", 0, int'(cnt[0]), 0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (busy[0]) seen++;
    end
    chk("no_frame_after_rst", 0, seen, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) begin
        vin[k] = ($urandom_range(0, 3) == 0);
        win[k] = 7'($urandom);
        clr[k] = ($urandom_range(0, 15) == 0);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      vin[k] = 1'b0;
      clr[k] = 1'b0;
    end
    wait_idle(0);
    wait_idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
